// File: rtl/output_writeback_pkg.sv
// Shared types, default geometry and helpers for the output write-back path.
package output_writeback_pkg;

  localparam int DEF_IO_DATA_WIDTH      = 16;
  localparam int DEF_FEATURE_MAP_WIDTH  = 1024;
  localparam int DEF_FEATURE_MAP_HEIGHT = 1024;
  localparam int DEF_OUTPUT_NB_CHANNELS = 64;
  localparam int DEF_ADDR_WIDTH         = 26;

  localparam int FRAME_WORDS = DEF_FEATURE_MAP_WIDTH * DEF_FEATURE_MAP_HEIGHT * DEF_OUTPUT_NB_CHANNELS;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]    addr;
    logic [DEF_IO_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } wb_state_t;

  function automatic int frame_words(input int w, input int h, input int c);
    return w * h * c;
  endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Pixel stream in, memory write port out; master is the environment, slave is the write-back block.
interface output_writeback_if
  import output_writeback_pkg::*;
  #(
    parameter int IO_DATA_WIDTH      = DEF_IO_DATA_WIDTH,
    parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH
  ) ();

  logic                                  in_valid;
  logic signed [IO_DATA_WIDTH-1:0]       in_data;
  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x;
  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y;
  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch;

  logic                     mem_write_en;
  logic [ADDR_WIDTH-1:0]    mem_write_addr;
  logic [IO_DATA_WIDTH-1:0] mem_din;
  logic                     mem_ready;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, mem_ready,
    input  mem_write_en, mem_write_addr, mem_din
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, mem_ready,
    output mem_write_en, mem_write_addr, mem_din
  );

endinterface

// File: rtl/output_writeback_wb_fifo.sv
// Synchronous FIFO of write-back entries; pointers carry an extra wrap bit to tell full from empty.
module wb_fifo
  import output_writeback_pkg::*;
  #(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 8
  ) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
  );

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0] wr_ptr;
  logic [IDX_W:0] rd_ptr;
  entry_t         mem [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (IDX_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/output_writeback.sv
// Converts the output-pixel stream into linear frame addresses and drains them into a stallable memory port.
module output_writeback
  import output_writeback_pkg::*;
  #(
    parameter int IO_DATA_WIDTH      = DEF_IO_DATA_WIDTH,
    parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
    parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
    parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
    parameter int FIFO_DEPTH         = 8,
    parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
    parameter int BASE_ADDR          = 0,
    localparam int FRAME_TOTAL = frame_words(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS),
    localparam int COUNT_WIDTH = $clog2(FRAME_TOTAL + 1)
  ) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   start,
    output_writeback_if.slave      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] write_count
  );

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [IO_DATA_WIDTH-1:0] data;
  } entry_t;

  wb_state_t state;
  wb_state_t state_next;
  logic      stage_valid;
  entry_t    stage_entry;
  entry_t    stage_next;
  entry_t    head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      transfer;
  logic      last_write;

  // Address is formed at full ADDR_WIDTH so nothing is truncated before the final sum.
  always_comb begin
    stage_next.addr = ADDR_WIDTH'(BASE_ADDR)
                    + (ADDR_WIDTH'(bus.in_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH) + ADDR_WIDTH'(bus.in_x))
                      * ADDR_WIDTH'(OUTPUT_NB_CHANNELS)
                    + ADDR_WIDTH'(bus.in_ch);
    stage_next.data = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst_in || start) stage_valid <= 1'b0;
    else                 stage_valid <= bus.in_valid && (state == ST_RUN);
    stage_entry <= stage_next;
  end

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_in),
    .flush     (start),
    .push      (stage_valid),
    .push_data (stage_entry),
    .pop       (transfer),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign transfer           = bus.mem_write_en && bus.mem_ready;
  assign last_write         = transfer && (write_count == COUNT_WIDTH'(FRAME_TOTAL - 1));
  assign bus.mem_write_en   = !fifo_empty;
  assign bus.mem_write_addr = fifo_empty ? '0 : head.addr;
  assign bus.mem_din        = fifo_empty ? '0 : head.data;

  always_ff @(posedge clk) begin
    if (rst_in || start) begin
      write_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (transfer) write_count <= write_count + COUNT_WIDTH'(1);
      if (stage_valid && fifo_full && !transfer) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_next;
  end

  // start wins from any state, restarting the frame.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_RUN: begin
        busy = 1'b1;
        if (last_write) state_next = ST_DONE;
      end
      ST_DONE: done = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    if (start) state_next = ST_RUN;
  end

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback on a 4x2x2 frame, 4-entry FIFO, frame based at address 100.
module tb_output_writeback;

  localparam int DW    = 16;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int C     = 2;
  localparam int DEPTH = 4;
  localparam int AW    = 26;
  localparam int BASE  = 100;
  localparam int FRAME = W * H * C;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_in;
  logic start;
  logic busy;
  logic done;
  logic overflow;
  logic [$clog2(FRAME+1)-1:0] write_count;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  exp_t e;

  logic          seen_en;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_din;
  logic          xfer_seen;

  output_writeback_if #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(C), .ADDR_WIDTH(AW)
  ) bus ();

  output_writeback #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .OUTPUT_NB_CHANNELS(C), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .start       (start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference address of a pixel, straight from the frame layout (row-major, channels innermost).
  function automatic logic [AW-1:0] ref_addr(input int x, input int y, input int ch);
    return AW'(BASE + (y * W + x) * C + ch);
  endfunction

  // One clock: drive inputs just after posedge, observe port at negedge, return just after next posedge.
  task automatic step(input logic v, input int x, input int y, input int ch,
                      input logic [DW-1:0] d, input logic rdy);
    bus.in_valid  = v;
    bus.in_x      = 2'(x);
    bus.in_y      = 1'(y);
    bus.in_ch     = 1'(ch);
    bus.in_data   = d;
    bus.mem_ready = rdy;
    @(negedge clk);
    seen_en   = bus.mem_write_en;
    seen_addr = bus.mem_write_addr;
    seen_din  = bus.mem_din;
    xfer_seen = bus.mem_write_en & bus.mem_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1'b0, 0, 0, 0, '0, 1'b0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    int en_count = 0;
    rst_in = 1'b1;
    start  = 1'b0;
    repeat (3) step(1'b0, 0, 0, 0, '0, 1'b1);
    checks++; if (bus.mem_write_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en got %0b exp 0", bus.mem_write_en); end
    checks++; if (bus.mem_write_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0d exp 0", bus.mem_write_addr); end
    checks++; if (bus.mem_din !== '0) begin errors++; $display("[TB] FAIL reset_din got %0d exp 0", bus.mem_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b exp 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %0b exp 0", overflow); end
    checks++; if (write_count !== 0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", write_count); end
    rst_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, i, 0, i % C, 16'h55, 1'b1);
      if (seen_en) en_count++;
    end
    repeat (3) begin
      step(1'b0, 0, 0, 0, '0, 1'b1);
      if (seen_en) en_count++;
    end
    checks++;
    if (en_count !== 0 || write_count !== 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_ignore got en_cycles %0d count %0d exp 0 0", en_count, write_count);
    end
  endtask

  task automatic test_full_frame();
    int sent = 0;
    int writes = 0;
    int dropped_writes = 0;
    logic v;
    exp_q.delete();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || write_count !== 0) begin
      errors++; $display("[TB] FAIL start_state got busy %0b done %0b count %0d exp 1 0 0", busy, done, write_count);
    end
    for (int cyc = 0; cyc < 60 && writes < FRAME; cyc++) begin
      v = (sent < FRAME);
      if (v) exp_q.push_back('{a: AW'(BASE + sent), d: DW'(sent)});
      step(v, (sent / C) % W, sent / (C * W), sent % C, DW'(sent), 1'b1);
      if (v) sent++;
      if (xfer_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL frame_extra_write got addr %0d exp none", seen_addr);
        end else begin
          e = exp_q.pop_front();
          if (seen_addr !== e.a || seen_din !== e.d) begin
            errors++; $display("[TB] FAIL frame_write%0d got addr %0d din %0d exp addr %0d din %0d", writes, seen_addr, seen_din, e.a, e.d);
          end
        end
        writes++;
        if (writes == FRAME - 1) begin
          checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL frame_done_early got %0b exp 0", done); end
        end
        if (writes == FRAME) begin
          checks++;
          if (done !== 1'b1 || write_count !== FRAME) begin
            errors++; $display("[TB] FAIL frame_done got done %0b count %0d exp 1 %0d", done, write_count, FRAME);
          end
        end
      end
    end
    checks++; if (writes !== FRAME) begin errors++; $display("[TB] FAIL frame_writes got %0d exp %0d", writes, FRAME); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL frame_overflow got %0b exp 0", overflow); end
    // Pixels arriving after the frame completes must be ignored.
    for (int i = 0; i < 6; i++) begin
      step(i < 2, 1, 1, 1, 16'h7777, 1'b1);
      if (xfer_seen) dropped_writes++;
    end
    checks++;
    if (dropped_writes !== 0 || write_count !== FRAME || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL done_ignore got writes %0d count %0d done %0b exp 0 %0d 1", dropped_writes, write_count, done, FRAME);
    end
  endtask

  task automatic test_single_pixel();
    int writes = 0;
    logic [DW-1:0] d;
    logic [AW-1:0] got_addr;
    logic [DW-1:0] got_din;
    d = DW'($urandom);
    got_addr = '0;
    got_din = '0;
    pulse_start();
    step(1'b1, 3, 1, 1, d, 1'b1);
    repeat (8) begin
      step(1'b0, 0, 0, 0, '0, 1'b1);
      if (xfer_seen) begin writes++; got_addr = seen_addr; got_din = seen_din; end
    end
    checks++; if (writes !== 1) begin errors++; $display("[TB] FAIL single_writes got %0d exp 1", writes); end
    checks++; if (got_addr !== AW'(115)) begin errors++; $display("[TB] FAIL single_addr got %0d exp 115", got_addr); end
    checks++; if (got_din !== d) begin errors++; $display("[TB] FAIL single_din got %0d exp %0d", got_din, d); end
    checks++;
    if (write_count !== 1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL single_count got %0d done %0b exp 1 0", write_count, done);
    end
  endtask

  task automatic test_overflow();
    int writes = 0;
    int x, y, ch;
    logic [DW-1:0] d;
    exp_q.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1); ch = $urandom_range(0, C - 1);
      d = DW'($urandom);
      if (i < DEPTH) exp_q.push_back('{a: ref_addr(x, y, ch), d: d});
      step(1'b1, x, y, ch, d, 1'b0);
    end
    repeat (3) step(1'b0, 0, 0, 0, '0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %0b exp 1", overflow); end
    checks++;
    if (seen_en !== 1'b1 || seen_addr !== exp_q[0].a) begin
      errors++; $display("[TB] FAIL ovf_head got en %0b addr %0d exp 1 %0d", seen_en, seen_addr, exp_q[0].a);
    end
    checks++; if (write_count !== 0) begin errors++; $display("[TB] FAIL ovf_stall_count got %0d exp 0", write_count); end
    repeat (12) begin
      step(1'b0, 0, 0, 0, '0, 1'b1);
      if (xfer_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL ovf_extra_write got addr %0d exp none", seen_addr);
        end else begin
          e = exp_q.pop_front();
          if (seen_addr !== e.a || seen_din !== e.d) begin
            errors++; $display("[TB] FAIL ovf_write%0d got addr %0d din %0d exp addr %0d din %0d", writes, seen_addr, seen_din, e.a, e.d);
          end
        end
        writes++;
      end
    end
    checks++; if (writes !== DEPTH) begin errors++; $display("[TB] FAIL ovf_writes got %0d exp %0d", writes, DEPTH); end
    checks++;
    if (write_count !== DEPTH || done !== 1'b0 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_final got count %0d done %0b ovf %0b exp %0d 0 1", write_count, done, overflow, DEPTH);
    end
  endtask

  task automatic test_full_throughput();
    int sent = 0;
    int writes = 0;
    int x, y, ch;
    logic v;
    logic [DW-1:0] d;
    exp_q.delete();
    pulse_start();
    for (int cyc = 0; cyc < 80 && writes < FRAME; cyc++) begin
      // First DEPTH pixels fill the FIFO against a stalled port, then stream every cycle.
      v = (sent < FRAME) && (cyc < DEPTH || cyc >= DEPTH + 2);
      x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1); ch = $urandom_range(0, C - 1);
      d = DW'($urandom);
      if (v) begin exp_q.push_back('{a: ref_addr(x, y, ch), d: d}); sent++; end
      step(v, x, y, ch, d, cyc >= DEPTH + 2);
      if (cyc == DEPTH + 1) begin
        checks++; if (seen_en !== 1'b1 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL thru_filled got en %0b ovf %0b exp 1 0", seen_en, overflow); end
      end
      if (xfer_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL thru_extra_write got addr %0d exp none", seen_addr);
        end else begin
          e = exp_q.pop_front();
          if (seen_addr !== e.a || seen_din !== e.d) begin
            errors++; $display("[TB] FAIL thru_write%0d got addr %0d din %0d exp addr %0d din %0d", writes, seen_addr, seen_din, e.a, e.d);
          end
        end
        writes++;
      end
    end
    checks++;
    if (writes !== FRAME || overflow !== 1'b0 || done !== 1'b1 || write_count !== FRAME) begin
      errors++; $display("[TB] FAIL thru_final got writes %0d ovf %0b done %0b count %0d exp %0d 0 1 %0d", writes, overflow, done, write_count, FRAME, FRAME);
    end
  endtask

  task automatic test_stall_toggle();
    int sent = 0;
    int writes = 0;
    int x, y, ch;
    logic v, rdy, prev_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] d, prev_din;
    prev_stall = 1'b0;
    prev_addr = '0;
    prev_din = '0;
    exp_q.delete();
    pulse_start();
    for (int cyc = 0; cyc < 300 && writes < FRAME; cyc++) begin
      rdy = (cyc % 2 == 0);
      v = (sent < FRAME) && (sent - writes < DEPTH) && ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1); ch = $urandom_range(0, C - 1);
      d = DW'($urandom);
      if (v) begin exp_q.push_back('{a: ref_addr(x, y, ch), d: d}); sent++; end
      step(v, x, y, ch, d, rdy);
      if (prev_stall) begin
        checks++;
        if (seen_en !== 1'b1 || seen_addr !== prev_addr || seen_din !== prev_din) begin
          errors++; $display("[TB] FAIL stall_hold got en %0b addr %0d din %0d exp 1 %0d %0d", seen_en, seen_addr, seen_din, prev_addr, prev_din);
        end
      end
      prev_stall = seen_en && !rdy;
      prev_addr = seen_addr;
      prev_din = seen_din;
      if (xfer_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL stall_extra_write got addr %0d exp none", seen_addr);
        end else begin
          e = exp_q.pop_front();
          if (seen_addr !== e.a || seen_din !== e.d) begin
            errors++; $display("[TB] FAIL stall_write%0d got addr %0d din %0d exp addr %0d din %0d", writes, seen_addr, seen_din, e.a, e.d);
          end
        end
        writes++;
      end
    end
    checks++;
    if (writes !== FRAME || done !== 1'b1 || overflow !== 1'b0 || write_count !== FRAME) begin
      errors++; $display("[TB] FAIL stall_final got writes %0d done %0b ovf %0b count %0d exp %0d 1 0 %0d", writes, done, overflow, write_count, FRAME, FRAME);
    end
  endtask

  task automatic test_reset_mid_frame();
    int sent = 0;
    int writes = 0;
    int en_count = 0;
    int x, y, ch;
    logic v;
    logic [DW-1:0] d;
    pulse_start();
    for (int i = 0; i < 5; i++) step(1'b1, (i / C) % W, i / (C * W), i % C, DW'($urandom), 1'b1);
    rst_in = 1'b1;
    step(1'b0, 0, 0, 0, '0, 1'b1);
    checks++;
    if (bus.mem_write_en !== 1'b0 || bus.mem_write_addr !== '0 || bus.mem_din !== '0) begin
      errors++; $display("[TB] FAIL midrst_port got en %0b addr %0d din %0d exp 0 0 0", bus.mem_write_en, bus.mem_write_addr, bus.mem_din);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || write_count !== 0) begin
      errors++; $display("[TB] FAIL midrst_state got busy %0b done %0b ovf %0b count %0d exp 0 0 0 0", busy, done, overflow, write_count);
    end
    rst_in = 1'b0;
    repeat (4) begin
      step(1'b0, 0, 0, 0, '0, 1'b1);
      if (seen_en) en_count++;
    end
    checks++; if (en_count !== 0) begin errors++; $display("[TB] FAIL midrst_leftover got %0d exp 0", en_count); end
    exp_q.delete();
    pulse_start();
    for (int cyc = 0; cyc < 300 && writes < FRAME; cyc++) begin
      v = (sent < FRAME) && (sent - writes < DEPTH) && ($urandom_range(0, 1) != 0);
      x = $urandom_range(0, W - 1); y = $urandom_range(0, H - 1); ch = $urandom_range(0, C - 1);
      d = DW'($urandom);
      if (v) begin exp_q.push_back('{a: ref_addr(x, y, ch), d: d}); sent++; end
      step(v, x, y, ch, d, 1'($urandom_range(0, 1)));
      if (xfer_seen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rerun_extra_write got addr %0d exp none", seen_addr);
        end else begin
          e = exp_q.pop_front();
          if (seen_addr !== e.a || seen_din !== e.d) begin
            errors++; $display("[TB] FAIL rerun_write%0d got addr %0d din %0d exp addr %0d din %0d", writes, seen_addr, seen_din, e.a, e.d);
          end
        end
        writes++;
      end
    end
    checks++;
    if (writes !== FRAME || done !== 1'b1 || write_count !== FRAME) begin
      errors++; $display("[TB] FAIL rerun_final got writes %0d done %0b count %0d exp %0d 1 %0d", writes, done, write_count, FRAME, FRAME);
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_full_frame();
    test_single_pixel();
    test_overflow();
    test_full_throughput();
    test_stall_toggle();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
